// File: rtl/irq_prio_sched.sv
// Three-bus (A > B > C) priority interrupt scheduler with request latching, ack/EOI handshake and grant timeout.
// Define IRQ_PRIO_SCHED_ROTATE_EN for round-robin arbitration within each bus; fixed lowest-index priority otherwise.
module irq_prio_sched #(
   parameter int NCH     = 9,
   parameter int CW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] req_a,
   input  logic [NCH-1:0] req_b,
   input  logic [NCH-1:0] req_c,
   input  logic [NCH-1:0] en_mask,
   input  logic           irq_ack,
   input  logic           eoi,
   output logic           irq,
   output logic [1:0]     irq_bus,
   output logic [CW-1:0]  irq_chan,
   output logic           busy,
   output logic           timeout_err
);

   // state   | meaning
   // IDLE    | nothing presented, waiting for an enabled pending bit
   // ARB     | one cycle: pick and register the winner
   // GRANT   | irq high, waiting for irq_ack or timeout
   // SERVICE | acked, waiting for eoi; winner still shown on irq_bus/irq_chan
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARB     = 2'd1,
      S_GRANT   = 2'd2,
      S_SERVICE = 2'd3
   } state_t;

   localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);
   localparam logic [1:0]    BUS_A    = 2'b01;
   localparam logic [1:0]    BUS_B    = 2'b10;
   localparam logic [1:0]    BUS_C    = 2'b11;
   localparam logic [NCH-1:0] ONE     = NCH'(1);

   state_t         state;
   logic [7:0]     cnt;
   logic [NCH-1:0] pend_a, pend_b, pend_c;
   logic [NCH-1:0] qual_a, qual_b, qual_c;
   logic [NCH-1:0] clr_a, clr_b, clr_c;
   logic [CW-1:0]  start_a, start_b, start_c;
   logic [CW:0]    pick_a, pick_b, pick_c;
   logic           any_qual;
   logic           win_valid;
   logic [1:0]     win_bus;
   logic [CW-1:0]  win_chan;
   logic           ack_take;

   // Circular search beginning just after 'start'; 'start' itself is examined last.
   // Iterating from lowest to highest priority lets the last hit stand as the winner.
   function automatic logic [CW:0] pick(input logic [NCH-1:0] v, input logic [CW-1:0] start);
      logic [CW:0] r;
      int          j;
      r = '0;
      for (int k = NCH; k >= 1; k--) begin
         j = int'(start) + k;
         if (j >= NCH) j = j - NCH;
         if (v[j]) r = {1'b1, CW'(j)};
      end
      return r;
   endfunction

`ifdef IRQ_PRIO_SCHED_ROTATE_EN
   logic [CW-1:0] last_a, last_b, last_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_a <= '0;
         last_b <= '0;
         last_c <= '0;
      end else if (ack_take) begin
         case (irq_bus)
            BUS_A:   last_a <= irq_chan;
            BUS_B:   last_b <= irq_chan;
            BUS_C:   last_c <= irq_chan;
            default: ;
         endcase
      end
   end

   assign start_a = last_a;
   assign start_b = last_b;
   assign start_c = last_c;
`else
   // A start of NCH-1 makes the circular search plain lowest-index-first.
   assign start_a = CW'(NCH - 1);
   assign start_b = CW'(NCH - 1);
   assign start_c = CW'(NCH - 1);
`endif

   assign qual_a   = pend_a & en_mask;
   assign qual_b   = pend_b & en_mask;
   assign qual_c   = pend_c & en_mask;
   assign any_qual = (|qual_a) | (|qual_b) | (|qual_c);

   assign pick_a = pick(qual_a, start_a);
   assign pick_b = pick(qual_b, start_b);
   assign pick_c = pick(qual_c, start_c);

   always_comb begin
      win_valid = 1'b1;
      win_bus   = 2'b00;
      win_chan  = '0;
      if (pick_a[CW]) begin
         win_bus  = BUS_A;
         win_chan = pick_a[CW-1:0];
      end else if (pick_b[CW]) begin
         win_bus  = BUS_B;
         win_chan = pick_b[CW-1:0];
      end else if (pick_c[CW]) begin
         win_bus  = BUS_C;
         win_chan = pick_c[CW-1:0];
      end else begin
         win_valid = 1'b0;
      end
   end

   assign ack_take = (state == S_GRANT) && irq_ack;

   // Clearing the acked bit takes precedence over a same-edge set of that bit.
   always_comb begin
      clr_a = '0;
      clr_b = '0;
      clr_c = '0;
      if (ack_take) begin
         case (irq_bus)
            BUS_A:   clr_a = ONE << irq_chan;
            BUS_B:   clr_b = ONE << irq_chan;
            BUS_C:   clr_c = ONE << irq_chan;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_a <= '0;
         pend_b <= '0;
         pend_c <= '0;
      end else begin
         pend_a <= (pend_a | (req_a & en_mask)) & ~clr_a;
         pend_b <= (pend_b | (req_b & en_mask)) & ~clr_b;
         pend_c <= (pend_c | (req_c & en_mask)) & ~clr_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         irq         <= 1'b0;
         irq_bus     <= 2'b00;
         irq_chan    <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_qual) begin
                  state <= S_ARB;
                  busy  <= 1'b1;
               end
            end
            S_ARB: begin
               if (win_valid) begin
                  state    <= S_GRANT;
                  irq      <= 1'b1;
                  irq_bus  <= win_bus;
                  irq_chan <= win_chan;
                  cnt      <= '0;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_GRANT: begin
               if (irq_ack) begin
                  state <= S_SERVICE;
                  irq   <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state       <= S_IDLE;
                  irq         <= 1'b0;
                  busy        <= 1'b0;
                  irq_bus     <= 2'b00;
                  irq_chan    <= '0;
                  timeout_err <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_SERVICE: begin
               if (eoi) begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  irq_bus  <= 2'b00;
                  irq_chan <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_prio_sched.sv
// Bench for irq_prio_sched: cycle-level behavioural model compared every cycle, plus directed literal checks.
module tb_irq_prio_sched;
   localparam int NCH     = 9;
   localparam int CW      = 4;
   localparam int TIMEOUT = 15;
`ifdef IRQ_PRIO_SCHED_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic           clk, rst_n;
   logic [NCH-1:0] req_a, req_b, req_c, en_mask;
   logic           irq_ack, eoi;
   logic           irq, busy, timeout_err;
   logic [1:0]     irq_bus;
   logic [CW-1:0]  irq_chan;

   int errors = 0;
   int checks = 0;
   bit cmp_on = 0;

   irq_prio_sched #(.NCH(NCH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .en_mask(en_mask), .irq_ack(irq_ack), .eoi(eoi), .irq(irq),
      .irq_bus(irq_bus), .irq_chan(irq_chan), .busy(busy), .timeout_err(timeout_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 arbitrate, 2 presenting, 3 servicing
   int m_phase, m_wbus, m_wchan, m_cnt, m_bus, m_chan;
   bit m_irq, m_busy, m_to;
   bit mp[3][NCH];
   bit nxt[3][NCH];
   int mlast[3];

   function automatic bit req_bit(input int b, input int i);
      case (b)
         0:       return req_a[i];
         1:       return req_b[i];
         default: return req_c[i];
      endcase
   endfunction

   // Walk buses in priority order; within a bus walk channels in search order.
   function automatic bit find_winner(output int wb, output int wc);
      wb = 0;
      wc = 0;
      for (int b = 0; b < 3; b++)
         for (int k = 1; k <= NCH; k++) begin
            int i;
            i = ROT ? (mlast[b] + k) % NCH : k - 1;
            if (mp[b][i] && en_mask[i]) begin
               wb = b;
               wc = i;
               return 1'b1;
            end
         end
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int wb, wc;
      if (!rst_n) begin
         m_phase = 0; m_cnt = 0; m_bus = 0; m_chan = 0; m_wbus = 0; m_wchan = 0;
         m_irq = 0; m_busy = 0; m_to = 0;
         for (int b = 0; b < 3; b++) begin
            mlast[b] = 0;
            for (int i = 0; i < NCH; i++) mp[b][i] = 0;
         end
      end else begin
         for (int b = 0; b < 3; b++)
            for (int i = 0; i < NCH; i++) nxt[b][i] = mp[b][i] | (req_bit(b, i) & en_mask[i]);
         m_to = 0;
         case (m_phase)
            0: if (find_winner(wb, wc)) begin m_phase = 1; m_busy = 1; end
            1: begin
               if (find_winner(wb, wc)) begin
                  m_phase = 2; m_irq = 1; m_wbus = wb; m_wchan = wc;
                  m_bus = wb + 1; m_chan = wc; m_cnt = 0;
               end else begin
                  m_phase = 0; m_busy = 0;
               end
            end
            2: begin
               if (irq_ack) begin
                  nxt[m_wbus][m_wchan] = 0;
                  mlast[m_wbus] = m_wchan;
                  m_phase = 3; m_irq = 0;
               end else if (m_cnt == TIMEOUT - 1) begin
                  m_phase = 0; m_irq = 0; m_busy = 0; m_to = 1; m_bus = 0; m_chan = 0;
               end else begin
                  m_cnt++;
               end
            end
            default: if (eoi) begin m_phase = 0; m_busy = 0; m_bus = 0; m_chan = 0; end
         endcase
         mp = nxt;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_irq", int'(irq), int'(m_irq));
         chk("model_bus", int'(irq_bus), m_bus);
         chk("model_chan", int'(irq_chan), m_chan);
         chk("model_busy", int'(busy), int'(m_busy));
         chk("model_timeout", int'(timeout_err), int'(m_to));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_irq(input string name);
      int n;
      n = 0;
      while (!irq && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_irq_arrived"}, int'(irq), 1);
   endtask

   task automatic ack_then_eoi();
      irq_ack = 1;
      @(negedge clk);
      irq_ack = 0;
      eoi = 1;
      @(negedge clk);
      eoi = 0;
   endtask

   task automatic idle_for(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(name, int'(busy), 0);
      end
   endtask

   int seq_exp[4];
   int cyc;

   initial begin
      rst_n = 0; req_a = '0; req_b = '0; req_c = '0; en_mask = '1; irq_ack = 0; eoi = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      cmp_on = 1;
      @(negedge clk);
      chk("reset_irq", int'(irq), 0);
      chk("reset_bus", int'(irq_bus), 0);
      chk("reset_busy", int'(busy), 0);

      // 1: single request on B5, latency, ack+eoi same cycle
      req_b[5] = 1;
      @(negedge clk); chk("t1_e0_irq", int'(irq), 0);
      @(negedge clk); chk("t1_e1_busy", int'(busy), 1); chk("t1_e1_irq", int'(irq), 0);
      @(negedge clk); chk("t1_e2_irq", int'(irq), 1);
      chk("t1_bus", int'(irq_bus), 2); chk("t1_chan", int'(irq_chan), 5);
      req_b[5] = 0;
      irq_ack = 1; eoi = 1;
      @(negedge clk);
      irq_ack = 0; eoi = 0;
      chk("t1_service_irq", int'(irq), 0); chk("t1_service_busy", int'(busy), 1);
      chk("t1_service_chan", int'(irq_chan), 5);
      eoi = 1;
      @(negedge clk);
      eoi = 0;
      chk("t1_idle_busy", int'(busy), 0); chk("t1_idle_bus", int'(irq_bus), 0);

      // 2: A7 beats C0, C0 follows
      req_a[7] = 1; req_c[0] = 1;
      @(negedge clk);
      req_a[7] = 0; req_c[0] = 0;
      wait_irq("t2a");
      chk("t2a_bus", int'(irq_bus), 1); chk("t2a_chan", int'(irq_chan), 7);
      ack_then_eoi();
      wait_irq("t2c");
      chk("t2c_bus", int'(irq_bus), 3); chk("t2c_chan", int'(irq_chan), 0);
      ack_then_eoi();

      // 3: one-cycle pulse is latched; masked pulse never pends
      req_b[2] = 1;
      @(negedge clk);
      req_b[2] = 0;
      wait_irq("t3");
      chk("t3_bus", int'(irq_bus), 2); chk("t3_chan", int'(irq_chan), 2);
      ack_then_eoi();
      en_mask[2] = 0;
      req_b[2] = 1;
      @(negedge clk);
      req_b[2] = 0;
      idle_for("t3_masked_busy", 6);
      en_mask[2] = 1;
      idle_for("t3_unmask_busy", 3);

      // 4: timeout after exactly TIMEOUT cycles, then regrant and ack
      req_a[3] = 1;
      @(negedge clk);
      req_a[3] = 0;
      wait_irq("t4");
      cyc = 0;
      while (irq && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
      chk("t4_irq_cycles", cyc, 15);
      chk("t4_timeout_pulse", int'(timeout_err), 1);
      @(negedge clk);
      chk("t4_timeout_single", int'(timeout_err), 0);
      wait_irq("t4_regrant");
      chk("t4_regrant_chan", int'(irq_chan), 3); chk("t4_regrant_bus", int'(irq_bus), 1);
      ack_then_eoi();
      idle_for("t4_cleared_busy", 5);

      // 5: async reset in the middle of a grant
      req_b[1] = 1; req_c[4] = 1;
      @(negedge clk);
      req_b[1] = 0; req_c[4] = 0;
      wait_irq("t5");
      #2 rst_n = 0;
      #1;
      chk("t5_async_irq", int'(irq), 0);
      chk("t5_async_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1;
      idle_for("t5_after_reset_busy", 8);

      // 6: two held requests on bus A
      seq_exp = ROT ? '{1, 4, 1, 4} : '{1, 1, 1, 1};
      req_a[1] = 1; req_a[4] = 1;
      for (int g = 0; g < 4; g++) begin
         wait_irq("t6");
         chk($sformatf("t6_grant%0d_chan", g), int'(irq_chan), seq_exp[g]);
         ack_then_eoi();
      end
      req_a = '0;
      repeat (30) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
